// File: rtl/car_request_latch.sv
// car_request_latch: conditioning for one car-sensor push button.
// The raw active-low key is synchronized, debounced by a four-state FSM and
// turned into a one-cycle press pulse plus a car request level that is held
// until the controller reports the car as served.
// Optional feature: define CAR_COUNT_EN to build the saturating press counter;
// without it press_count is tied to zero.
module car_request_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       served,
  output logic       key_level,
  output logic       press_pulse,
  output logic       request,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    UP,
    UP_WAIT,
    DOWN,
    DOWN_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic             sync1;
  logic             sync2;
  logic             pressed_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Two-flop synchronizer; both stages rest at the released level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  // A press is accepted on the edge the FSM moves into DOWN from the released side.
  always_comb begin
    accept = 1'b0;
    if (pressed_s) begin
      if (state == UP && ONE_SHOT)
        accept = 1'b1;
      else if (state == UP_WAIT && cnt == CNT_MAX)
        accept = 1'b1;
    end
  end

  // Debounce FSM with registered level and press pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= UP;
      cnt         <= '0;
      key_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      unique case (state)
        UP: begin
          key_level <= 1'b0;
          if (pressed_s) begin
            if (ONE_SHOT) begin
              state       <= DOWN;
              key_level   <= 1'b1;
              press_pulse <= 1'b1;
              cnt         <= '0;
            end else begin
              state <= UP_WAIT;
              cnt   <= CNT_ONE;
            end
          end
        end
        UP_WAIT: begin
          if (!pressed_s) begin
            state <= UP;
            cnt   <= '0;
          end else if (accept) begin
            state       <= DOWN;
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DOWN: begin
          key_level <= 1'b1;
          if (!pressed_s) begin
            if (ONE_SHOT) begin
              state     <= UP;
              key_level <= 1'b0;
              cnt       <= '0;
            end else begin
              state <= DOWN_WAIT;
              cnt   <= CNT_ONE;
            end
          end
        end
        DOWN_WAIT: begin
          if (pressed_s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= UP;
            key_level <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= UP;
          cnt       <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

  // Request latch: set together with the pulse, and a served that lands in
  // the pulse cycle cannot clear it because a new car has just arrived.
  always_ff @(posedge clock) begin
    if (reset)
      request <= 1'b0;
    else if (accept || press_pulse)
      request <= 1'b1;
    else if (served)
      request <= 1'b0;
  end

`ifdef CAR_COUNT_EN
  // Saturating count of accepted presses, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)
      press_count <= '0;
    else if (accept && press_count != 8'hFF)
      press_count <= press_count + 8'd1;
  end
`else
  assign press_count = '0;
`endif

endmodule
